// File: rtl/tis_exec_unit.sv
// tis_exec_unit: execution sequencer for one TIS-100 node.
// Latches a decoded op and fetches its source from the immediate or the
// inbound port. It drives the external combinational alu, then retires the
// result into ACC/BAK and pulses done.
module tis_exec_unit #(
  parameter int              W        = 11,
  parameter logic [W-1:0]    ACC_INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic         op_src_sel,
  input  logic [W-1:0] op_imm,
  input  logic         port_in_valid,
  output logic         port_in_ready,
  input  logic [W-1:0] port_in_data,
  output logic [1:0]   alu_instr,
  output logic [W-1:0] alu_acc,
  output logic [W-1:0] alu_src,
  input  logic [W-1:0] alu_out,
  output logic [W-1:0] acc,
  output logic [W-1:0] bak,
  output logic         done
);

  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_SAV = 3'b101;
  localparam logic [2:0] OP_SWP = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_SRC = 2'b01,
    EXEC     = 2'b10
  } state_t;

  state_t       state_reg, state_next;
  logic [2:0]   op_code_reg;
  logic [1:0]   alu_instr_reg;
  logic [W-1:0] alu_acc_reg, alu_src_reg;
  logic [W-1:0] acc_reg, bak_reg;
  logic         done_reg;

  logic accept;
  logic port_hs;
  logic op_is_alu;
  logic op_needs_port;
  logic [1:0] op_alu_instr;

  assign op_ready      = (state_reg == IDLE);
  assign port_in_ready = (state_reg == WAIT_SRC);
  assign accept        = op_valid & op_ready;
  assign port_hs       = port_in_valid & port_in_ready;

  // Decode the incoming op: alu instruction mapping and port requirement.
  always_comb begin
    op_is_alu     = 1'b0;
    op_needs_port = 1'b0;
    op_alu_instr  = 2'b00;
    case (op_code)
      OP_MOV: begin op_is_alu = 1'b1; op_alu_instr = 2'b11; op_needs_port = op_src_sel; end
      OP_ADD: begin op_is_alu = 1'b1; op_alu_instr = 2'b00; op_needs_port = op_src_sel; end
      OP_SUB: begin op_is_alu = 1'b1; op_alu_instr = 2'b01; op_needs_port = op_src_sel; end
      OP_NEG: begin op_is_alu = 1'b1; op_alu_instr = 2'b10; end
      default: ;
    endcase
  end

  // Next-state logic for the IDLE / WAIT_SRC / EXEC sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept) state_next = op_needs_port ? WAIT_SRC : EXEC;
      WAIT_SRC: if (port_in_valid) state_next = EXEC;
      EXEC:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register; reset discards any in-flight op immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath: latch op, load alu operands, retire into ACC/BAK, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_code_reg   <= 3'b000;
      alu_instr_reg <= 2'b00;
      alu_acc_reg   <= '0;
      alu_src_reg   <= '0;
      acc_reg       <= ACC_INIT;
      bak_reg       <= ACC_INIT;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        op_code_reg <= op_code;
        // Non-alu ops leave the alu operands untouched.
        if (op_is_alu) begin
          alu_instr_reg <= op_alu_instr;
          alu_acc_reg   <= acc_reg;
          alu_src_reg   <= op_imm;
        end
      end
      if (port_hs) begin
        alu_src_reg <= port_in_data;
        alu_acc_reg <= acc_reg;
      end
      if (state_reg == EXEC) begin
        done_reg <= 1'b1;
        case (op_code_reg)
          OP_MOV, OP_ADD, OP_SUB, OP_NEG: acc_reg <= alu_out;
          OP_SAV: bak_reg <= acc_reg;
          OP_SWP: begin
            acc_reg <= bak_reg;
            bak_reg <= acc_reg;
          end
          default: ;
        endcase
      end
    end
  end

  assign alu_instr = alu_instr_reg;
  assign alu_acc   = alu_acc_reg;
  assign alu_src   = alu_src_reg;
  assign acc       = acc_reg;
  assign bak       = bak_reg;
  assign done      = done_reg;

endmodule
